// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and sizing helpers for the systolic sequencer.
// Revision    : 1.0
// ============================================================================
package systolic_pkg;

    localparam int DIM_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_LOAD_A  = 2'd0,
        OP_LOAD_B  = 2'd1,
        OP_COMPUTE = 2'd2,
        OP_READ_C  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_RUN   = 3'd3,
        S_READ  = 3'd4
    } state_t;

    function automatic int rowbits(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    function automatic int run_cycles(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_counter
// Description : Loadable down-counter with zero flag; stops at zero.
// Revision    : 1.0
// ============================================================================
module seq_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/systolic_seq.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq
// Description : Command sequencer driving memA/memB/systolic-array strobes.
// Revision    : 1.0
// ============================================================================
module systolic_seq
    import systolic_pkg::*;
#(
    parameter  int DIM     = DIM_DEFAULT,
    localparam int ROWBITS = rowbits(DIM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ROWBITS-1:0] cmd_row,
    output logic               a_WrEn,
    output logic [ROWBITS-1:0] Arow,
    output logic               b_WrEn,
    output logic               mem_en,
    output logic               sa_clr,
    output logic               sa_en,
    output logic [ROWBITS-1:0] Crow,
    output logic               c_valid,
    output logic               done,
    output logic               err,
    output logic               busy
);

    localparam int               CW         = ROWBITS + 2;
    localparam logic [CW-1:0]    c_run_load = CW'(run_cycles(DIM) - 1);
    localparam logic [CW-1:0]    c_rd_load  = CW'(DIM - 1);
    localparam logic [ROWBITS:0] c_b_full   = (ROWBITS + 1)'(DIM);

    state_t r_state, w_state_nxt;
    op_t    w_op;

    // Every output is a flop; the *_nxt values are what appears next cycle.
    logic               r_ready, r_awr, r_bwr, r_run, r_clr, r_cval, r_done, r_err;
    logic [ROWBITS-1:0] r_arow, r_crow;
    logic               w_ready_nxt, w_awr_nxt, w_bwr_nxt, w_run_nxt, w_clr_nxt;
    logic               w_cval_nxt, w_done_nxt, w_err_nxt;
    logic [ROWBITS-1:0] w_arow_nxt, w_crow_nxt;

    logic [DIM-1:0]     r_amask;
    logic [ROWBITS:0]   r_bcnt;
    logic               r_stale;
    logic               w_set_a, w_set_b, w_clr_ops, w_stale_clr;

    logic               w_accept;
    logic               w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [CW-1:0]      w_cnt_val, w_cnt;

    assign w_op     = op_t'(cmd_op);
    assign w_accept = cmd_valid & r_ready;

    seq_counter #(
        .WIDTH (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .dec      (w_cnt_dec),
        .count    (w_cnt),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = 1'b0;
        w_awr_nxt   = 1'b0;
        w_arow_nxt  = '0;
        w_bwr_nxt   = 1'b0;
        w_run_nxt   = 1'b0;
        w_clr_nxt   = 1'b0;
        w_cval_nxt  = 1'b0;
        w_crow_nxt  = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_cnt_dec   = 1'b0;
        w_set_a     = 1'b0;
        w_set_b     = 1'b0;
        w_clr_ops   = 1'b0;
        w_stale_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_LOAD_A: begin
                            w_state_nxt = S_LOAD;
                            w_awr_nxt   = 1'b1;
                            w_arow_nxt  = cmd_row;
                            w_done_nxt  = 1'b1;
                            w_set_a     = 1'b1;
                        end
                        OP_LOAD_B: begin
                            w_state_nxt = S_LOAD;
                            w_bwr_nxt   = 1'b1;
                            w_done_nxt  = 1'b1;
                            w_set_b     = 1'b1;
                        end
                        OP_COMPUTE: begin
                            if ((&r_amask) && (r_bcnt == c_b_full)) begin
                                w_state_nxt = S_CLEAR;
                                w_clr_nxt   = 1'b1;
                            end else begin
                                w_err_nxt   = 1'b1;
                            end
                        end
                        OP_READ_C: begin
                            if (!r_stale) begin
                                w_state_nxt = S_READ;
                                w_cval_nxt  = 1'b1;
                                w_done_nxt  = (c_rd_load == '0);
                                w_cnt_load  = 1'b1;
                                w_cnt_val   = c_rd_load;
                            end else begin
                                w_err_nxt   = 1'b1;
                            end
                        end
                        default: w_err_nxt = 1'b1;
                    endcase
                end else begin
                    // Also the path out of an err cycle, where ready is held low.
                    w_ready_nxt = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
            S_CLEAR: begin
                w_state_nxt = S_RUN;
                w_run_nxt   = 1'b1;
                w_done_nxt  = (c_run_load == '0);
                w_cnt_load  = 1'b1;
                w_cnt_val   = c_run_load;
                w_clr_ops   = 1'b1;
            end
            S_RUN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                    w_stale_clr = 1'b1;
                end else begin
                    w_cnt_dec   = 1'b1;
                    w_run_nxt   = 1'b1;
                    w_done_nxt  = (w_cnt == CW'(1));
                end
            end
            S_READ: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_dec   = 1'b1;
                    w_cval_nxt  = 1'b1;
                    w_crow_nxt  = r_crow + 1'b1;
                    w_done_nxt  = (w_cnt == CW'(1));
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_awr   <= 1'b0;
            r_arow  <= '0;
            r_bwr   <= 1'b0;
            r_run   <= 1'b0;
            r_clr   <= 1'b0;
            r_cval  <= 1'b0;
            r_crow  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_awr   <= w_awr_nxt;
            r_arow  <= w_arow_nxt;
            r_bwr   <= w_bwr_nxt;
            r_run   <= w_run_nxt;
            r_clr   <= w_clr_nxt;
            r_cval  <= w_cval_nxt;
            r_crow  <= w_crow_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Operand completeness and result freshness tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amask <= '0;
            r_bcnt  <= '0;
            r_stale <= 1'b1;
        end else begin
            if (w_clr_ops) begin
                r_amask <= '0;
                r_bcnt  <= '0;
            end else begin
                if (w_set_a) begin
                    r_amask[cmd_row] <= 1'b1;
                end
                if (w_set_b && (r_bcnt != c_b_full)) begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
            if (w_set_a || w_set_b) begin
                r_stale <= 1'b1;
            end else if (w_stale_clr) begin
                r_stale <= 1'b0;
            end
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = ~r_ready;
    assign a_WrEn    = r_awr;
    assign Arow      = r_arow;
    assign b_WrEn    = r_bwr;
    assign mem_en    = r_run;
    assign sa_en     = r_run;
    assign sa_clr    = r_clr;
    assign Crow      = r_crow;
    assign c_valid   = r_cval;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/systolic_seq.md
# systolic_seq

Command-driven sequencer for the matrix-multiply unit: it owns the control inputs of memA, memB and the systolic array, and the top level routes the data buses (Ain, Bin, C) directly. It accepts one command at a time (load an A row, push a B vector, compute, read C), generates cycle-exact write/shift/clear/read strobes, and tracks operand completeness. It rejects a compute or read that would consume incomplete or stale data.

## Interface
- DIM, 8, matrix dimension (rows/cols of A, B, C)
- ROWBITS, $clog2(DIM), row index width (derived, not overridden)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  2  0 LOAD_A, 1 LOAD_B, 2 COMPUTE, 3 READ_C
- cmd_row  in  ROWBITS  A row for LOAD_A; ignored otherwise
- a_WrEn  out  1  memA write strobe
- Arow  out  ROWBITS  memA row being written
- b_WrEn  out  1  memB write strobe (shifts one Bin vector in)
- mem_en  out  1  shift enable to memA and memB
- sa_clr  out  1  clear systolic accumulators
- sa_en  out  1  systolic array advance
- Crow  out  ROWBITS  C row on read
- c_valid  out  1  Crow valid / C row on the bus
- done  out  1  one-cycle pulse, command completed
- err  out  1  one-cycle pulse, command rejected
- busy  out  1  equal to ~cmd_ready

## Operation
- States: IDLE, LOAD, CLEAR, RUN, READ.
- Accept: cmd_valid & cmd_ready at edge T. All outputs are registered, so the first effect appears in cycle T+1.
- LOAD_A: LOAD for 1 cycle. a_WrEn=1, Arow=cmd_row. Sets a_mask[cmd_row]. done in the same cycle. Reloading a row is legal.
- LOAD_B: LOAD for 1 cycle. b_WrEn=1. b_cnt saturates at DIM. done in the same cycle. A 9th+ push is still issued (memB shifts), and b_cnt stays DIM.
- COMPUTE: legal only if a_mask all ones and b_cnt==DIM. Otherwise err at T+1, return to IDLE, no strobes.
  - CLEAR 1 cycle (sa_clr=1). Clears a_mask and b_cnt.
  - RUN for RUN_CYCLES=3*DIM-2 cycles, with mem_en=sa_en=1.
  - done on the last RUN cycle. c_stale cleared at that edge.
- READ_C: legal only if c_stale==0. Otherwise err at T+1.
  - READ for DIM cycles, with Crow=0..DIM-1 and c_valid=1. done with Crow=DIM-1.
  - C is not consumed; repeated reads are legal.
- c_stale: reset 1. Set by any accepted LOAD_A/LOAD_B. Cleared on COMPUTE completion.
- Outputs not listed for a state are 0. Arow and Crow hold 0 outside LOAD and READ.

## Timing
- Reset (async, any state): state IDLE, cmd_ready=1, every other output 0, a_mask=0, b_cnt=0, c_stale=1, run counter 0.
- Latency, accept to done: LOAD 1 cycle, COMPUTE 1+RUN_CYCLES = 3*DIM-1 cycles (23 at DIM=8), READ_C DIM cycles.
- cmd_ready is low from T+1 until the cycle after done/err. The earliest next accept is the edge at the end of the done/err cycle.
- Back-to-back LOAD_A commands therefore issue a_WrEn every 2 cycles.
- cmd_valid while busy is ignored, not queued. cmd_op/cmd_row are sampled only at accept.
- Run counter: ROWBITS+2 bits, loaded with RUN_CYCLES-1 in CLEAR, decremented in RUN, exit at 0. No wrap.
- done and err are never high in the same cycle.
- Reset mid-RUN: strobes drop asynchronously. Memory/array contents are undefined, and c_stale=1 blocks READ_C.

## Structure
- Package systolic_pkg holds:
  - the op_t enum for cmd_op
  - the state_t enum
  - DIM default, and ROWBITS and RUN_CYCLES as functions of DIM
- Sub-module seq_counter: loadable down-counter with a zero flag, reused for RUN and READ lengths.
- Everything else (FSM, a_mask, b_cnt, c_stale) lives in systolic_seq.

## Test plan
- Reset then COMPUTE -> err at T+1, no sa_clr/mem_en, cmd_ready back high at T+2.
- LOAD_A rows 0..7 plus 8x LOAD_B, then COMPUTE:
  - sa_clr at T+1
  - mem_en=sa_en high for exactly 22 cycles (T+2..T+23)
  - done at T+23
  - a golden 8x8 int8 product matches C
- READ_C after a good compute -> Crow 0..7 on 8 consecutive cycles with c_valid. Repeat read gives identical data.
- LOAD_A rows 0..6 only (7 missing) plus 8 B pushes, then COMPUTE -> err. Then load row 7 and COMPUTE -> runs and completes.
- A single LOAD_B after a compute, then READ_C -> err, no c_valid. Also check b_cnt saturation: 10 pushes followed by the remaining A loads lets COMPUTE run.
- Assert rst_n low at RUN cycle 10 -> all strobes 0 immediately, cmd_ready=1 after release, and a following READ_C -> err.
